// File: rtl/cache_maint_seq_if.sv
// cache_maint_seq_if: command handshake and cache_ctrl scan port bundle
interface cache_maint_seq_if;
  logic         cmd_vld_i;
  logic         cmd_rdy_o;
  logic [1:0]   cmd_op_i;
  logic [31:0]  cmd_addr_i;
  logic [127:0] cmd_data_i;
  logic [3:0]   cmd_maskn_i;
  logic         done_o;
  logic         err_o;
  logic         busy_o;
  logic         scan_enb_o;
  logic [8:0]   scan_addr_o;
  logic [31:0]  scan_data_o;
  logic [3:0]   scan_web_tag_o;
  logic [3:0]   scan_web_cache_o;
  modport slave (
    input  cmd_vld_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_maskn_i,
    output cmd_rdy_o, done_o, err_o, busy_o,
    output scan_enb_o, scan_addr_o, scan_data_o, scan_web_tag_o, scan_web_cache_o
  );
  modport master (
    output cmd_vld_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_maskn_i,
    input  cmd_rdy_o, done_o, err_o, busy_o,
    input  scan_enb_o, scan_addr_o, scan_data_o, scan_web_tag_o, scan_web_cache_o
  );
endinterface

// File: rtl/cache_maint_seq.sv
// cache_maint_seq: expands fill/invalidate/invalidate-all commands into cache_ctrl scan-port beats
module cache_maint_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_SETS      = 128
) (
  input logic clk,
  input logic reset,
  cache_maint_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DATA, TAG, SWEEP, SETTLE} state_t;
  localparam logic [6:0] LAST      = 7'(NUM_SETS - 1);
  localparam logic [2:0] SET_LAST  = 3'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
  localparam bit         NO_SETTLE = SETTLE_CYCLES == 0;
  state_t state, state_n;
  logic [6:0] cnt, cnt_n;
  logic [2:0] scnt, scnt_n;
  logic [1:0] op, op_n;
  logic [31:2] addr, addr_n;
  logic [127:0] data, data_n;
  logic [3:0] maskn, maskn_n;
  logic acc, fin, enb_n;
  logic [8:0] saddr_n;
  logic [31:0] sdata_n;
  logic [3:0] wt_n, wc_n;
  assign bus.cmd_rdy_o = state == IDLE && reset;
  assign bus.busy_o    = state != IDLE;
  assign acc           = bus.cmd_vld_i && bus.cmd_rdy_o;
  always_comb begin
    op_n    = acc ? bus.cmd_op_i : op;
    addr_n  = acc ? bus.cmd_addr_i[31:2] : addr;
    data_n  = acc ? bus.cmd_data_i : data;
    maskn_n = acc ? bus.cmd_maskn_i : maskn;
    state_n = state;
    cnt_n   = cnt;
    scnt_n  = scnt;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        scnt_n = '0;
        if (acc)
          state_n = bus.cmd_op_i == 2'b01 ? TAG :
                    bus.cmd_op_i == 2'b10 ? DATA :
                    bus.cmd_op_i == 2'b11 ? SWEEP : SETTLE;
      end
      DATA: begin
        cnt_n = cnt == 7'd3 ? '0 : cnt + 7'd1;
        state_n = cnt == 7'd3 ? TAG : DATA;
      end
      TAG, SWEEP: begin
        cnt_n = cnt == LAST ? cnt : cnt + 7'd1;
        if (state == TAG || cnt == LAST) begin
          state_n = NO_SETTLE ? IDLE : SETTLE;
          scnt_n = SET_LAST;
          fin = NO_SETTLE;
        end
      end
      SETTLE: begin
        scnt_n = scnt - 7'd1 == '0 ? '0 : scnt - 3'd1;
        state_n = scnt == '0 ? IDLE : SETTLE;
        fin = scnt == '0;
      end
      default: state_n = IDLE;
    endcase
    enb_n   = !(state_n inside {DATA, TAG, SWEEP});
    saddr_n = state_n == DATA  ? {addr_n[8:2], cnt_n[1:0]} :
              state_n == TAG   ? {2'b00, addr_n[8:2]} :
              state_n == SWEEP ? {2'b00, cnt_n} : '0;
    sdata_n = state_n == DATA ? data_n[32*cnt_n[1:0] +: 32] :
              state_n == TAG && op_n == 2'b10 ? {1'b1, 8'b0, addr_n[31:9]} : '0;
    wc_n    = state_n == DATA ? maskn_n : 4'hf;
    wt_n    = state_n == TAG ? (op_n == 2'b10 ? maskn_n : 4'h0) :
              state_n == SWEEP ? 4'h0 : 4'hf;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      scnt <= '0;
      op <= '0;
      addr <= '0;
      data <= '0;
      maskn <= '0;
      bus.done_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.scan_enb_o <= 1'b1;
      bus.scan_addr_o <= '0;
      bus.scan_data_o <= '0;
      bus.scan_web_tag_o <= 4'hf;
      bus.scan_web_cache_o <= 4'hf;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      scnt <= scnt_n;
      op <= op_n;
      addr <= addr_n;
      data <= data_n;
      maskn <= maskn_n;
      bus.done_o <= (fin && op != 2'b00) || (acc && bus.cmd_op_i == 2'b00);
      bus.err_o <= acc && bus.cmd_op_i == 2'b00;
      bus.scan_enb_o <= enb_n;
      bus.scan_addr_o <= saddr_n;
      bus.scan_data_o <= sdata_n;
      bus.scan_web_tag_o <= wt_n;
      bus.scan_web_cache_o <= wc_n;
    end
  end
endmodule

// File: tb/tb_cache_maint_seq.sv
// tb_cache_maint_seq: directed self-checking bench for cache_maint_seq
module tb_cache_maint_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  cache_maint_seq_if bus();
  cache_maint_seq #(.SETTLE_CYCLES(2), .NUM_SETS(128)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " enb"}, bus.scan_enb_o, 1'b1);
    chk({tag, " wt"}, bus.scan_web_tag_o, 4'hf);
    chk({tag, " wc"}, bus.scan_web_cache_o, 4'hf);
    chk({tag, " addr"}, bus.scan_addr_o, 9'h0);
    chk({tag, " data"}, bus.scan_data_o, 32'h0);
  endtask
  task automatic beat_chk(input string tag, input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] wt, input logic [3:0] wc);
    chk({tag, " enb"}, bus.scan_enb_o, 1'b0);
    chk({tag, " addr"}, bus.scan_addr_o, a);
    chk({tag, " data"}, bus.scan_data_o, d);
    chk({tag, " wt"}, bus.scan_web_tag_o, wt);
    chk({tag, " wc"}, bus.scan_web_cache_o, wc);
  endtask
  task automatic junk();
    bus.cmd_op_i = 2'(3 - int'(bus.cmd_op_i));
    bus.cmd_addr_i = $urandom;
    bus.cmd_data_i = {$urandom, $urandom, $urandom, $urandom};
    bus.cmd_maskn_i = 4'(~bus.cmd_maskn_i);
  endtask
  initial begin
    logic [127:0] d1, d2;
    d1 = 128'h00004444_00003333_00002222_00001111;
    d2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    bus.cmd_vld_i = 1'b0;
    bus.cmd_op_i = 2'b00;
    bus.cmd_addr_i = '0;
    bus.cmd_data_i = '0;
    bus.cmd_maskn_i = 4'hf;
    tick();
    tick();
    idle_chk("reset");
    chk("reset busy", bus.busy_o, 1'b0);
    chk("reset rdy", bus.cmd_rdy_o, 1'b0);
    chk("reset done", bus.done_o, 1'b0);
    chk("reset err", bus.err_o, 1'b0);
    reset = 1'b1;
    #1;
    chk("post-reset rdy", bus.cmd_rdy_o, 1'b1);
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b10;
    bus.cmd_addr_i = 32'h0000_1A44;
    bus.cmd_data_i = d1;
    bus.cmd_maskn_i = 4'h0;
    tick();
    bus.cmd_vld_i = 1'b0;
    junk();
    for (int i = 0; i < 4; i++) begin
      beat_chk($sformatf("fill beat%0d", i), 9'(9'h044 + i), d1[32*i +: 32], 4'hf, 4'h0);
      chk("fill busy", bus.busy_o, 1'b1);
      tick();
    end
    beat_chk("fill tag", 9'h011, 32'h8000_000D, 4'h0, 4'hf);
    tick();
    idle_chk("fill settle1");
    chk("fill settle1 done", bus.done_o, 1'b0);
    chk("fill settle1 busy", bus.busy_o, 1'b1);
    tick();
    idle_chk("fill settle2");
    chk("fill settle2 done", bus.done_o, 1'b0);
    tick();
    chk("fill done", bus.done_o, 1'b1);
    chk("fill rdy", bus.cmd_rdy_o, 1'b1);
    chk("fill busy end", bus.busy_o, 1'b0);
    tick();
    chk("fill done pulse", bus.done_o, 1'b0);
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b01;
    bus.cmd_addr_i = 32'h0000_01FC;
    tick();
    bus.cmd_vld_i = 1'b0;
    junk();
    beat_chk("inval beat", 9'h07F, 32'h0, 4'h0, 4'hf);
    tick();
    idle_chk("inval settle1");
    tick();
    idle_chk("inval settle2");
    chk("inval early done", bus.done_o, 1'b0);
    tick();
    chk("inval done", bus.done_o, 1'b1);
    chk("inval rdy", bus.cmd_rdy_o, 1'b1);
    chk("inval enb", bus.scan_enb_o, 1'b1);
    tick();
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b11;
    bus.cmd_addr_i = 32'hFFFF_FFFF;
    tick();
    bus.cmd_vld_i = 1'b0;
    junk();
    for (int k = 0; k < 128; k++) begin
      beat_chk($sformatf("sweep%0d", k), 9'(k), 32'h0, 4'h0, 4'hf);
      tick();
    end
    idle_chk("sweep settle1");
    chk("sweep settle1 done", bus.done_o, 1'b0);
    tick();
    chk("sweep settle2 done", bus.done_o, 1'b0);
    tick();
    chk("sweep done", bus.done_o, 1'b1);
    chk("sweep rdy", bus.cmd_rdy_o, 1'b1);
    tick();
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b01;
    bus.cmd_addr_i = 32'h0000_01FC;
    tick();
    bus.cmd_op_i = 2'b10;
    bus.cmd_addr_i = 32'hFFFF_FE08;
    bus.cmd_data_i = d2;
    bus.cmd_maskn_i = 4'b0110;
    beat_chk("b2b inval", 9'h07F, 32'h0, 4'h0, 4'hf);
    chk("b2b rdy low", bus.cmd_rdy_o, 1'b0);
    tick();
    chk("b2b busy1", bus.busy_o, 1'b1);
    tick();
    chk("b2b busy2", bus.busy_o, 1'b1);
    tick();
    chk("b2b done", bus.done_o, 1'b1);
    chk("b2b accept rdy", bus.cmd_rdy_o, 1'b1);
    tick();
    bus.cmd_vld_i = 1'b0;
    junk();
    for (int i = 0; i < 4; i++) begin
      beat_chk($sformatf("b2b fill beat%0d", i), 9'(9'h008 + i), d2[32*i +: 32], 4'hf, 4'b0110);
      tick();
    end
    beat_chk("b2b fill tag", 9'h002, 32'h807F_FFFF, 4'b0110, 4'hf);
    tick();
    tick();
    tick();
    chk("b2b fill done", bus.done_o, 1'b1);
    tick();
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b10;
    bus.cmd_addr_i = 32'h0000_1A44;
    bus.cmd_data_i = d1;
    bus.cmd_maskn_i = 4'h0;
    tick();
    bus.cmd_vld_i = 1'b0;
    tick();
    tick();
    beat_chk("rst fill beat2", 9'h046, 32'h3333, 4'hf, 4'h0);
    reset = 1'b0;
    tick();
    idle_chk("rst mid");
    chk("rst mid busy", bus.busy_o, 1'b0);
    chk("rst mid rdy", bus.cmd_rdy_o, 1'b0);
    chk("rst mid done", bus.done_o, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst release rdy", bus.cmd_rdy_o, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst no done", bus.done_o, 1'b0);
      chk("rst no beat", bus.scan_enb_o, 1'b1);
    end
    bus.cmd_vld_i = 1'b1;
    bus.cmd_op_i = 2'b00;
    tick();
    bus.cmd_op_i = 2'b01;
    bus.cmd_addr_i = 32'h0;
    chk("rsv err", bus.err_o, 1'b1);
    chk("rsv done", bus.done_o, 1'b1);
    chk("rsv rdy", bus.cmd_rdy_o, 1'b0);
    chk("rsv busy", bus.busy_o, 1'b1);
    idle_chk("rsv beat");
    tick();
    chk("rsv err pulse", bus.err_o, 1'b0);
    chk("rsv done pulse", bus.done_o, 1'b0);
    chk("rsv next rdy", bus.cmd_rdy_o, 1'b1);
    chk("rsv enb", bus.scan_enb_o, 1'b1);
    tick();
    bus.cmd_vld_i = 1'b0;
    beat_chk("rsv next inval", 9'h000, 32'h0, 4'h0, 4'hf);
    tick();
    tick();
    tick();
    chk("rsv next done", bus.done_o, 1'b1);
    chk("rsv next err", bus.err_o, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
